// File: rtl/fft2d_out_collector_pkg.sv
// Shared constants and state encoding for the FFT2D output collector slice.
`timescale 1ns/1ps
package fft2d_out_collector_pkg;

    localparam int unsigned FFT_DATA_WIDTH = 16;
    localparam int unsigned FFT_ROW_LEN    = 32;

    typedef enum logic [1:0] {
        FFT_OUT_IDLE    = 2'd0,
        FFT_OUT_COLLECT = 2'd1,
        FFT_OUT_DRAIN   = 2'd2
    } fft_out_state_e;

endpackage

// File: rtl/fft2d_out_fifo.sv
// Dual-pointer row FIFO with full/empty flags and a registered read port.
`timescale 1ns/1ps
module fft2d_out_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              last_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic [DATA_W-1:0] rd_data_q;

    // Storage is not reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_en_i) begin
                rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    assign rd_data_o = rd_data_q;
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // One word left: the next read empties the FIFO.
    assign last_o    = ((wr_ptr_q - rd_ptr_q) == PTR_ONE);

endmodule

// File: rtl/fft2d_out_collector.sv
// Collects one row of unit results, then drains it to the host bus on read strobes.
`timescale 1ns/1ps
module fft2d_out_collector
    import fft2d_out_collector_pkg::*;
#(
    parameter int unsigned DATA_W  = FFT_DATA_WIDTH,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned ROW_LEN = FFT_ROW_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] unit_data,
    input  logic              unit_valid,
    output logic              unit_ready,
    input  logic              ext_cs,
    input  logic              ext_rd_en,
    output logic [DATA_W-1:0] ext_data,
    output logic              ext_valid,
    output logic              ext_oe,
    output logic              empty,
    output logic              full,
    output logic              row_done,
    output logic              drain_done,
    output logic              rd_err
);

    localparam int unsigned   CW        = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam logic [CW-1:0] WCNT_LAST = CW'(ROW_LEN - 1);
    localparam logic [CW-1:0] WCNT_ONE  = CW'(1);

    fft_out_state_e state_q;
    logic [CW-1:0]  wcnt_q;
    logic           ext_valid_q;
    logic           row_done_q;
    logic           drain_done_q;
    logic           rd_err_q;

    logic wr_en;
    logic rd_req;
    logic rd_en;
    logic fifo_last;

    assign wr_en  = (state_q == FFT_OUT_COLLECT) && unit_valid && !full;
    assign rd_req = (state_q == FFT_OUT_DRAIN) && ext_cs && ext_rd_en;
    assign rd_en  = rd_req && !empty;

    fft2d_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .wr_en_i   (wr_en),
        .wr_data_i (unit_data),
        .rd_en_i   (rd_en),
        .rd_data_o (ext_data),
        .empty_o   (empty),
        .full_o    (full),
        .last_o    (fifo_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FFT_OUT_IDLE;
            wcnt_q       <= '0;
            ext_valid_q  <= 1'b0;
            row_done_q   <= 1'b0;
            drain_done_q <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            ext_valid_q  <= rd_en;
            rd_err_q     <= rd_req && empty;
            row_done_q   <= 1'b0;
            drain_done_q <= 1'b0;
            case (state_q)
                FFT_OUT_IDLE: begin
                    if (start) begin
                        state_q <= FFT_OUT_COLLECT;
                    end
                end
                FFT_OUT_COLLECT: begin
                    if (wr_en) begin
                        if (wcnt_q == WCNT_LAST) begin
                            state_q    <= FFT_OUT_DRAIN;
                            wcnt_q     <= '0;
                            row_done_q <= 1'b1;
                        end else begin
                            wcnt_q <= wcnt_q + WCNT_ONE;
                        end
                    end
                end
                FFT_OUT_DRAIN: begin
                    if (rd_en && fifo_last) begin
                        state_q      <= FFT_OUT_IDLE;
                        drain_done_q <= 1'b1;
                    end
                end
                default: state_q <= FFT_OUT_IDLE;
            endcase
        end
    end

    assign unit_ready = (state_q == FFT_OUT_COLLECT) && !full;
    assign ext_oe     = (state_q == FFT_OUT_DRAIN) && ext_cs;
    assign ext_valid  = ext_valid_q;
    assign row_done   = row_done_q;
    assign drain_done = drain_done_q;
    assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_fft2d_out_collector.sv
// Bench for fft2d_out_collector: queue-based reference model plus small-parameter boundary runs.
`timescale 1ns/1ps
module tb_fft2d_out_collector;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start, uv, cs, rd;
    logic [W-1:0] ud;
    logic         ready, evalid, oe, empty, full, rdone, ddone, rerr;
    logic [W-1:0] edata;

    logic         b_start, b_uv, b_cs, b_rd;
    logic [W-1:0] b_ud;
    logic         b_ready, b_evalid, b_oe, b_empty, b_full, b_rdone, b_ddone, b_rerr;
    logic [W-1:0] b_edata;

    logic         c_start, c_uv, c_cs, c_rd;
    logic [W-1:0] c_ud;
    logic         c_ready, c_evalid, c_oe, c_empty, c_full, c_rdone, c_ddone, c_rerr;
    logic [W-1:0] c_edata;

    fft2d_out_collector #(.DATA_W(W), .DEPTH(32), .ROW_LEN(32)) dut (
        .clk(clk), .reset(rst_n), .start(start), .unit_data(ud), .unit_valid(uv),
        .unit_ready(ready), .ext_cs(cs), .ext_rd_en(rd), .ext_data(edata),
        .ext_valid(evalid), .ext_oe(oe), .empty(empty), .full(full),
        .row_done(rdone), .drain_done(ddone), .rd_err(rerr));

    fft2d_out_collector #(.DATA_W(W), .DEPTH(16), .ROW_LEN(16)) dut_b (
        .clk(clk), .reset(rst_n), .start(b_start), .unit_data(b_ud), .unit_valid(b_uv),
        .unit_ready(b_ready), .ext_cs(b_cs), .ext_rd_en(b_rd), .ext_data(b_edata),
        .ext_valid(b_evalid), .ext_oe(b_oe), .empty(b_empty), .full(b_full),
        .row_done(b_rdone), .drain_done(b_ddone), .rd_err(b_rerr));

    fft2d_out_collector #(.DATA_W(W), .DEPTH(2), .ROW_LEN(1)) dut_c (
        .clk(clk), .reset(rst_n), .start(c_start), .unit_data(c_ud), .unit_valid(c_uv),
        .unit_ready(c_ready), .ext_cs(c_cs), .ext_rd_en(c_rd), .ext_data(c_edata),
        .ext_valid(c_evalid), .ext_oe(c_oe), .empty(c_empty), .full(c_full),
        .row_done(c_rdone), .drain_done(c_ddone), .rd_err(c_rerr));

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 = waiting for start, 1 = taking a row, 2 = handing it out.
    int           mode;
    int           taken;
    logic [W-1:0] q[$];
    logic [W-1:0] m_data;

    task automatic step(input logic s, input logic u, input logic [W-1:0] d,
                        input logic c, input logic r);
        logic nv, nrow, ndrain, nerr;
        start = s; uv = u; ud = d; cs = c; rd = r;
        #1;
        chk("unit_ready", ready, (mode == 1) && (q.size() < 32));
        chk("ext_oe", oe, (mode == 2) && c);
        nv = 1'b0; nrow = 1'b0; ndrain = 1'b0; nerr = 1'b0;
        if (mode == 0) begin
            if (s) mode = 1;
        end else if (mode == 1) begin
            if (u && q.size() < 32) begin
                q.push_back(d);
                taken++;
                if (taken == 32) begin
                    mode = 2; taken = 0; nrow = 1'b1;
                end
            end
        end else if (c && r) begin
            if (q.size() > 0) begin
                m_data = q.pop_front();
                nv = 1'b1;
                if (q.size() == 0) begin
                    mode = 0; ndrain = 1'b1;
                end
            end else begin
                nerr = 1'b1;
            end
        end
        @(posedge clk); #1;
        chk("ext_valid", evalid, nv);
        chk("ext_data", edata, m_data);
        chk("row_done", rdone, nrow);
        chk("drain_done", ddone, ndrain);
        chk("rd_err", rerr, nerr);
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == 32);
    endtask

    task automatic check_reset_values();
        chk("rst_unit_ready", ready, 0);
        chk("rst_ext_valid", evalid, 0);
        chk("rst_ext_data", edata, 0);
        chk("rst_ext_oe", oe, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_row_done", rdone, 0);
        chk("rst_drain_done", ddone, 0);
        chk("rst_rd_err", rerr, 0);
    endtask

    task automatic do_reset();
        start = 0; uv = 0; ud = '0; cs = 1; rd = 1;
        rst_n = 0;
        #1;
        check_reset_values();
        mode = 0; taken = 0; q.delete(); m_data = '0;
        @(posedge clk); #1;
        rst_n = 1;
        cs = 0; rd = 0;
    endtask

    task automatic full_row(input logic [W-1:0] base);
        step(1, 0, '0, 0, 0);
        for (int i = 0; i < 32; i++) step(0, 1, W'(base + W'(i)), 0, 0);
        for (int i = 0; i < 32; i++) step(0, 0, '0, 1, 1);
    endtask

    initial begin
        rst_n = 0;
        start = 0; uv = 0; ud = '0; cs = 0; rd = 0;
        b_start = 0; b_uv = 0; b_ud = '0; b_cs = 0; b_rd = 0;
        c_start = 0; c_uv = 0; c_ud = '0; c_cs = 0; c_rd = 0;
        mode = 0; taken = 0; m_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1;

        // Partial row followed by a reset.
        step(1, 0, '0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, W'(16'h0E00 + i), 0, 0);
        do_reset();

        // Nominal row; unit_valid stays high into DRAIN and host strobes in COLLECT.
        step(1, 0, '0, 1, 1);
        for (int i = 0; i < 32; i++) step(0, 1, W'(i), 1, (i % 3) == 0);
        for (int i = 0; i < 3; i++) step(0, 1, 16'hDEAD, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, (i % 2) == 0, 0);
        for (int i = 0; i < 32; i++) step(0, 0, '0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 1);

        // Back-to-back rows crossing the pointer wrap.
        full_row(16'hA000);
        full_row(16'hB000);
        full_row(16'hC000);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, W'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
        end

        // DEPTH = ROW_LEN = 16 full boundary.
        b_start = 1; @(posedge clk); #1; b_start = 0;
        b_uv = 1;
        for (int i = 0; i < 16; i++) begin
            b_ud = W'(16'h0100 + i);
            chk("b_unit_ready", b_ready, 1);
            @(posedge clk); #1;
            if (i == 14) chk("b_full_early", b_full, 0);
        end
        chk("b_full", b_full, 1);
        chk("b_row_done", b_rdone, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("b_ready_drain", b_ready, 0);
            chk("b_full_hold", b_full, 1);
        end
        b_uv = 0; b_cs = 1; b_rd = 1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            chk("b_ext_valid", b_evalid, 1);
            chk("b_ext_data", b_edata, 16'h0100 + i);
        end
        chk("b_drain_done", b_ddone, 1);
        chk("b_empty", b_empty, 1);
        @(posedge clk); #1;
        chk("b_rd_err_idle", b_rerr, 0);
        b_cs = 0; b_rd = 0;

        // ROW_LEN = 1: a second strobe lands after the FSM has returned to IDLE.
        c_start = 1; @(posedge clk); #1; c_start = 0;
        c_uv = 1; c_ud = 16'h5A5A;
        @(posedge clk); #1;
        c_uv = 0;
        chk("c_row_done", c_rdone, 1);
        chk("c_empty", c_empty, 0);
        c_cs = 1; c_rd = 1;
        @(posedge clk); #1;
        chk("c_ext_valid", c_evalid, 1);
        chk("c_ext_data", c_edata, 16'h5A5A);
        chk("c_drain_done", c_ddone, 1);
        @(posedge clk); #1;
        chk("c_second_valid", c_evalid, 0);
        chk("c_rd_err", c_rerr, 0);
        chk("c_oe_idle", c_oe, 0);
        c_cs = 0; c_rd = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fft2d_out_collector.md
# fft2d_out_collector

Output-side companion to the FFT2D input buffer. It accepts one row of FFT results from the processing units into an internal FIFO. Once the row is complete, it drains the row to the external host bus under host read strobes and asserts the drive enable that the top level uses for the bidirectional port. One row is in flight at a time; the unit side and the host side never overlap.

## Interface
Parameters:
- DATA_W, default `FFT_DATA_WIDTH: word width.
- DEPTH, default 32: FIFO entries; power of 2; DEPTH >= ROW_LEN.
- ROW_LEN, default 32: words per row, one per unit.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that arms collection of a row.
- unit_data  in  DATA_W  result word from the units.
- unit_valid  in  1  unit_data is valid.
- unit_ready  out  1  collector accepts unit_data this cycle.
- ext_cs  in  1  host selects the output side.
- ext_rd_en  in  1  host read strobe.
- ext_data  out  DATA_W  registered read data.
- ext_valid  out  1  ext_data is valid this cycle.
- ext_oe  out  1  top-level tri-state enable for the bidirectional port.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- row_done  out  1  one-cycle pulse: row fully collected.
- drain_done  out  1  one-cycle pulse: row fully read out.
- rd_err  out  1  one-cycle pulse: read strobe while empty in DRAIN.

## Operation
- States are IDLE, COLLECT and DRAIN.
- IDLE -> COLLECT on start. start is ignored in any other state.
- COLLECT:
  - unit_ready = ~full.
  - A write occurs on unit_valid & unit_ready: mem[wr_ptr] <= unit_data, wr_ptr++, wcnt++.
  - A write with wcnt == ROW_LEN-1 moves to DRAIN and clears wcnt.
  - Host reads are ignored in COLLECT: ext_valid stays 0 and no rd_err is raised.
- DRAIN:
  - unit_ready = 0.
  - ext_oe = ext_cs.
  - A read occurs on ext_cs & ext_rd_en & ~empty: ext_data <= mem[rd_ptr], rd_ptr++.
  - A read that empties the FIFO moves to IDLE.
  - ext_cs & ext_rd_en & empty -> rd_err pulse; state and pointers are unchanged.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and the lower bits are equal.
- Wrap-around across rows is seamless: pointers are never reset between rows.
- Reset at any point, including mid-row, discards partial data. It does not flush mem contents, which are don't-care.

## Timing
- Reset values:
  - state = IDLE; pointers and wcnt = 0.
  - ext_data = 0; ext_valid = 0; ext_oe = 0; unit_ready = 0.
  - empty = 1; full = 0.
  - row_done = drain_done = rd_err = 0.
- start sampled in cycle t -> unit_ready = 1 in cycle t+1, provided the FIFO is not full.
- Write latency: a word accepted at edge t is visible in the empty/full flags after edge t.
- row_done is high in the cycle after the final accepting edge. The state is DRAIN in that same cycle.
- Read latency is 1 cycle: strobe in cycle t -> ext_data and ext_valid in cycle t+1. ext_valid is high for exactly one cycle per read.
- Back-to-back strobes give one word per cycle with no bubbles.
- drain_done is high in the cycle after the read that empties the FIFO. The state is IDLE in that same cycle. A start in that cycle is honoured.
- ext_oe is combinational from ext_cs and state: no register stage, so the bus turns around within the same cycle.
- rd_err is registered and is high in the cycle after the offending strobe.

## Structure
- Shared defines header (alongside `FFT_DATA_WIDTH):
  - FFT_OUT_IDLE / FFT_OUT_COLLECT / FFT_OUT_DRAIN 2-bit state encodings.
  - Default ROW_LEN constant.
- One sub-module, fft2d_out_fifo:
  - Contents: dual-pointer storage, the full/empty flags and the registered read port.
  - Controls: wr/rd enables driven by the FSM in the top-level block.
- The FSM, wcnt, pulse outputs and ext_oe stay in fft2d_out_collector.

## Test plan
- Reset mid-row: assert start, write 5 words, pull reset low for 1 cycle -> all outputs at reset values, state IDLE, empty = 1. A following start + 32 words collects a clean row.
- Nominal row: start, then 32 words 0x0000..0x001F with unit_valid held high -> row_done one cycle after the 32nd, unit_ready = 0. Then ext_cs and ext_rd_en high for 32 cycles -> ext_data 0x0000..0x001F in consecutive cycles, drain_done once, empty = 1.
- Unit backpressure with DEPTH = 32: full asserts after word 32 together with the DRAIN transition, and unit_valid held high in DRAIN causes no writes. A bench run with DEPTH = 16, ROW_LEN = 16 checks the same boundary.
- Pointer wrap: run 3 back-to-back rows of 32 words with distinct patterns (0xA000+i, 0xB000+i, 0xC000+i) -> every row is read back in order, with no stale data at the wrap.
- Read errors and gating:
  - ext_rd_en in COLLECT -> no ext_valid, no rd_err.
  - After drain_done, with ext_cs & ext_rd_en high in IDLE -> no rd_err.
  - The rd_err check uses DRAIN with the FIFO forced empty via a row of ROW_LEN = 1 read twice in the same cycle window: the second strobe pulses rd_err only if the state is still DRAIN. Otherwise the strobe is ignored.
- Bus enable: toggle ext_cs in DRAIN without ext_rd_en -> ext_oe follows ext_cs in the same cycle, and no data is consumed.
